// File: rtl/conv_pkg.sv
// conv_pkg: shared geometry, state encoding and window-slot helpers for the
// conv window sequencer.
package conv_pkg;

  localparam int IMG_W = 64;
  localparam int AW    = 12;
  localparam int DW    = 20;
  localparam int NSLOT = 9;

  localparam logic [3:0] SLOT_FIRST       = 4'd0;
  localparam logic [3:0] SLOT_REUSE_FIRST = 4'd2;
  localparam logic [3:0] SLOT_LAST        = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LAST  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_WRITE = 3'd5
  } state_e;

  // Slot k sits at (dy,dx) = (k/3-1, k%3-1), returned as 2-bit two's complement.
  function automatic logic [1:0] slot_dx(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: return 2'b11;
      4'd1, 4'd4, 4'd7: return 2'b00;
      default:          return 2'b01;
    endcase
  endfunction

  function automatic logic [1:0] slot_dy(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: return 2'b11;
      4'd3, 4'd4, 4'd5: return 2'b00;
      default:          return 2'b01;
    endcase
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
    return v[DW-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/conv_window_buf.sv
// conv_window_buf: 3x3 window register file (load, zero, shift-left-column)
// packed row-major onto the engine's pixel bus, slot 0 in the top word.
module conv_window_buf
  import conv_pkg::*;
#(
  parameter int DW = conv_pkg::DW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ld_en,
  input  logic                ld_zero,
  input  logic [3:0]          ld_slot,
  input  logic [DW-1:0]       ld_data,
  input  logic                sh_en,
  output logic [NSLOT*DW-1:0] pixel
);

  logic [DW-1:0] win_q [NSLOT];
  logic [DW-1:0] win_d [NSLOT];

  always_comb begin
    win_d = win_q;
    if (sh_en) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]   = win_q[3*r+1];
        win_d[3*r+1] = win_q[3*r+2];
      end
    end
    for (int k = 0; k < NSLOT; k++) begin
      if (ld_en && (ld_slot == 4'(k))) begin
        win_d[k] = ld_zero ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NSLOT; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      win_q <= win_d;
    end
  end

  always_comb begin
    pixel = '0;
    for (int k = 0; k < NSLOT; k++) begin
      pixel[(NSLOT-1-k)*DW +: DW] = win_q[k];
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: raster-order 3x3 window sequencer in front of the conv engine.
// Build option CONV_WINDOW_REUSE_EN keeps two window columns between x steps.
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter int IMG_W = conv_pkg::IMG_W,
  parameter int AW    = conv_pkg::AW,
  parameter int DW    = conv_pkg::DW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ready,
  output logic            busy,
  output logic [AW-1:0]   iaddr,
  input  logic [DW-1:0]   idata,
  output logic [9*DW-1:0] pixel,
  output logic            start,
  input  logic [DW-1:0]   result_fixed,
  input  logic            finish,
  output logic            cwr,
  output logic [AW-1:0]   caddr_wr,
  output logic [DW-1:0]   cdata_wr
);

  // state | meaning
  // IDLE  | waiting for ready, busy low
  // FETCH | issue one window slot address per cycle, store previous slot
  // LAST  | store the final slot returned by image memory
  // START | one-cycle start pulse to the engine
  // WAIT  | window frozen until finish, then latch ReLU(result)
  // WRITE | write strobe to layer-0 memory, advance (x,y)

  localparam int CW = $clog2(IMG_W);
  localparam logic [CW-1:0] XY_MAX = CW'(IMG_W - 1);
`ifdef CONV_WINDOW_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [3:0]    slot_q, slot_d, pend_slot_q, pend_slot_d, slot_step;
  logic          pend_v_q, pend_v_d, pend_ok_q, pend_ok_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] ihold_q;
  logic [DW-1:0] cdata_q, cdata_d;
  logic [1:0]    dx, dy;
  logic [CW+1:0] xx, yy;
  logic          slot_ok, last_pos, x_last;
  logic          ld_en, ld_zero, sh_en;
  logic [3:0]    ld_slot;

  // Neighbour coordinate with two guard bits: any set guard bit means off-image.
  assign dx      = slot_dx(slot_q);
  assign dy      = slot_dy(slot_q);
  assign xx      = {2'b00, x_q} + {{CW{dx[1]}}, dx};
  assign yy      = {2'b00, y_q} + {{CW{dy[1]}}, dy};
  assign slot_ok = (xx[CW+1:CW] == 2'b00) && (yy[CW+1:CW] == 2'b00);
  assign x_last  = (x_q == XY_MAX);
  assign last_pos = x_last && (y_q == XY_MAX);
  assign slot_step = (REUSE && (x_q != '0)) ? 4'd3 : 4'd1;

  assign iaddr    = ((state_q == ST_FETCH) && slot_ok) ? {yy[CW-1:0], xx[CW-1:0]} : ihold_q;
  assign busy     = busy_q;
  assign caddr_wr = {y_q, x_q};
  assign cdata_wr = cdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (ready) state_d = ST_FETCH;
      ST_FETCH: if (slot_q == SLOT_LAST) state_d = ST_LAST;
      ST_LAST:  state_d = ST_START;
      ST_START: state_d = ST_WAIT;
      ST_WAIT:  if (finish) state_d = ST_WRITE;
      ST_WRITE: state_d = last_pos ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    slot_d      = slot_q;
    pend_slot_d = pend_slot_q;
    pend_v_d    = pend_v_q;
    pend_ok_d   = pend_ok_q;
    busy_d      = busy_q;
    cdata_d     = cdata_q;
    ld_en       = 1'b0;
    ld_zero     = 1'b0;
    ld_slot     = pend_slot_q;
    sh_en       = 1'b0;
    start       = 1'b0;
    cwr         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ready) begin
          x_d    = '0;
          y_d    = '0;
          slot_d = SLOT_FIRST;
          busy_d = 1'b1;
        end
      end
      ST_FETCH: begin
        ld_en       = pend_v_q;
        ld_zero     = !pend_ok_q;
        pend_v_d    = 1'b1;
        pend_slot_d = slot_q;
        pend_ok_d   = slot_ok;
        slot_d      = slot_q + slot_step;
      end
      ST_LAST: begin
        ld_en    = pend_v_q;
        ld_zero  = !pend_ok_q;
        pend_v_d = 1'b0;
      end
      ST_START: start = 1'b1;
      ST_WAIT: begin
        if (finish) cdata_d = relu(result_fixed);
      end
      ST_WRITE: begin
        cwr = 1'b1;
        x_d = x_q + 1'b1;
        if (x_last) y_d = y_q + 1'b1;
        if (last_pos) busy_d = 1'b0;
        // Reuse only when the next position stays on the same row.
        if (REUSE && !x_last) begin
          sh_en  = 1'b1;
          slot_d = SLOT_REUSE_FIRST;
        end else begin
          slot_d = SLOT_FIRST;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q         <= '0;
      y_q         <= '0;
      slot_q      <= '0;
      pend_slot_q <= '0;
      pend_v_q    <= 1'b0;
      pend_ok_q   <= 1'b0;
      busy_q      <= 1'b0;
      ihold_q     <= '0;
      cdata_q     <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      slot_q      <= slot_d;
      pend_slot_q <= pend_slot_d;
      pend_v_q    <= pend_v_d;
      pend_ok_q   <= pend_ok_d;
      busy_q      <= busy_d;
      ihold_q     <= iaddr;
      cdata_q     <= cdata_d;
    end
  end

  conv_window_buf #(.DW(DW)) u_win (
    .clk     (clk),
    .reset   (reset),
    .ld_en   (ld_en),
    .ld_zero (ld_zero),
    .ld_slot (ld_slot),
    .ld_data (idata),
    .sh_en   (sh_en),
    .pixel   (pixel)
  );

endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: image memory holding mem[a]=a, randomized engine stub,
// and a reference window/ReLU model computed directly from image coordinates.
`timescale 1ns/1ps
module tb_conv_window_ctrl;

  localparam int IMG_W = 64;
  localparam int AW    = 12;
  localparam int DW    = 20;
  localparam int NPOS  = IMG_W * IMG_W;
`ifdef CONV_WINDOW_REUSE_EN
  localparam int FETCH_GAP = 5;
`else
  localparam int FETCH_GAP = 11;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            ready;
  logic            busy;
  logic [AW-1:0]   iaddr;
  logic [DW-1:0]   idata;
  logic [9*DW-1:0] pixel;
  logic            start;
  logic [DW-1:0]   result_fixed;
  logic            finish;
  logic            cwr;
  logic [AW-1:0]   caddr_wr;
  logic [DW-1:0]   cdata_wr;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_idx  = 0;
  int eng_cnt  = 0;
  int n_starts = 0;
  int n_cwr    = 0;
  int force_l  = 0;
  int cyc      = 0;
  int wr_cyc   = 0;
  int addr_bad = 0;
  logic [DW-1:0] eng_res;
  logic [AW-1:0] prev_iaddr = '0;
  logic [DW-1:0] res_q[$];

  conv_window_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .ready        (ready),
    .busy         (busy),
    .iaddr        (iaddr),
    .idata        (idata),
    .pixel        (pixel),
    .start        (start),
    .result_fixed (result_fixed),
    .finish       (finish),
    .cwr          (cwr),
    .caddr_wr     (caddr_wr),
    .cdata_wr     (cdata_wr)
  );

  always #5 clk = ~clk;

  // Synchronous image memory, word at address a holds a.
  always @(posedge clk) idata <= DW'(iaddr);

  task automatic check_eq(input string tag, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] img(input int yy, input int xx);
    if (yy < 0 || yy >= IMG_W || xx < 0 || xx >= IMG_W) return '0;
    return DW'(yy * IMG_W + xx);
  endfunction

  function automatic logic [9*DW-1:0] window_of(input int idx);
    logic [9*DW-1:0] w;
    int px;
    int py;
    w  = '0;
    px = idx % IMG_W;
    py = idx / IMG_W;
    for (int k = 0; k < 9; k++) w = {w[8*DW-1:0], img(py + k / 3 - 1, px + k % 3 - 1)};
    return w;
  endfunction

  function automatic logic [9*DW-1:0] pack9(input int a0, input int a1, input int a2,
                                            input int a3, input int a4, input int a5,
                                            input int a6, input int a7, input int a8);
    return {DW'(a0), DW'(a1), DW'(a2), DW'(a3), DW'(a4), DW'(a5), DW'(a6), DW'(a7), DW'(a8)};
  endfunction

  function automatic logic [DW-1:0] relu_ref(input logic [DW-1:0] r);
    if ($signed(r) < 0) return '0;
    return r;
  endfunction

  function automatic bit nbr_ok(input logic [AW-1:0] a, input int idx);
    int ax;
    int ay;
    int px;
    int py;
    ax = int'(a) % IMG_W;
    ay = int'(a) / IMG_W;
    px = idx % IMG_W;
    py = idx / IMG_W;
    return (ax - px >= -1) && (ax - px <= 1) && (ay - py >= -1) && (ay - py <= 1);
  endfunction

  // Engine stub and stream checker, sampled on the falling edge.
  initial begin
    finish       = 1'b0;
    result_fixed = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset !== 1'b1) begin
        eng_cnt = 0;
        finish  = 1'b0;
        exp_idx = 0;
        res_q.delete();
      end else begin
        if (busy && (iaddr != prev_iaddr) && !nbr_ok(iaddr, exp_idx)) addr_bad++;
        finish = 1'b0;
        if (eng_cnt > 0) begin
          check_eq("start_single", start, 1'b0);
          check_eq("pixel_hold", pixel, window_of(exp_idx));
          eng_cnt--;
          if (eng_cnt == 0) begin
            finish       = 1'b1;
            result_fixed = eng_res;
            res_q.push_back(eng_res);
          end
        end else if (start) begin
          check_eq("pixel_start", pixel, window_of(exp_idx));
          if (exp_idx == 0)
            check_eq("pixel_0_0", pixel, pack9(0, 0, 0, 0, 0, 1, 0, 64, 65));
          if (exp_idx == 5 * IMG_W + 5)
            check_eq("pixel_5_5", pixel, pack9(260, 261, 262, 324, 325, 326, 388, 389, 390));
          if (exp_idx == NPOS - 1)
            check_eq("pixel_63_63", pixel, pack9(4030, 4031, 0, 4094, 4095, 0, 0, 0, 0));
          if (exp_idx == 1) check_eq("fetch_gap", cyc - wr_cyc, FETCH_GAP);
          if (force_l > 0)        eng_cnt = force_l;
          else if (n_starts == 0) eng_cnt = 11;
          else if (n_starts == 1) eng_cnt = 30;
          else                    eng_cnt = $urandom_range(1, 3);
          if (n_starts == 0)      eng_res = 20'hFF000;
          else if (n_starts == 1) eng_res = 20'h01800;
          else                    eng_res = DW'($urandom);
          n_starts++;
        end
        if (cwr) begin
          check_eq("caddr_wr", caddr_wr, exp_idx);
          if (res_q.size() == 0) begin
            check_eq("cwr_without_finish", 1'b1, 1'b0);
          end else begin
            check_eq("cdata_wr", cdata_wr, relu_ref(res_q.pop_front()));
          end
          if (n_cwr == 0) check_eq("relu_neg", cdata_wr, 20'h00000);
          if (n_cwr == 1) check_eq("relu_pos", cdata_wr, 20'h01800);
          if (exp_idx == 0) wr_cyc = cyc;
          exp_idx++;
          n_cwr++;
        end
      end
      prev_iaddr = iaddr;
    end
  end

  initial begin
    int extra;
    bit hit;
    reset = 1'b0;
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_start", start, 1'b0);
    check_eq("rst_cwr", cwr, 1'b0);
    check_eq("rst_iaddr", iaddr, 0);
    check_eq("rst_caddr", caddr_wr, 0);
    check_eq("rst_cdata", cdata_wr, 0);
    check_eq("rst_pixel", pixel, 0);
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", busy, 1'b0);
    #1 ready = 1'b1;
    @(negedge clk);
    check_eq("busy_rise", busy, 1'b1);
    #1 ready = 1'b0;

    for (int c = 0; c < 70000 && exp_idx < NPOS; c++) begin
      @(negedge clk);
      #1;
      if (c == 5000) ready = 1'b1;
      if (c == 5001) ready = 1'b0;
    end
    check_eq("frame_writes", exp_idx, NPOS);
    @(negedge clk);
    check_eq("busy_fall", busy, 1'b0);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (cwr || start || busy) extra++;
    end
    check_eq("post_frame_quiet", extra, 0);
    check_eq("iaddr_in_range", addr_bad, 0);

    // Second frame, interrupted by reset in the WAIT of output 2.
    #1;
    exp_idx = 0;
    res_q.delete();
    force_l = 20;
    ready   = 1'b1;
    @(negedge clk);
    #1 ready = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      #1;
      if (exp_idx == 2 && eng_cnt > 0 && eng_cnt < 20) hit = 1'b1;
    end
    check_eq("reached_wait", hit, 1'b1);
    reset = 1'b0;
    #1;
    check_eq("rstw_busy", busy, 1'b0);
    check_eq("rstw_start", start, 1'b0);
    check_eq("rstw_cwr", cwr, 1'b0);
    check_eq("rstw_iaddr", iaddr, 0);
    check_eq("rstw_caddr", caddr_wr, 0);
    check_eq("rstw_cdata", cdata_wr, 0);
    check_eq("rstw_pixel", pixel, 0);
    repeat (3) @(negedge clk);
    #1;
    reset   = 1'b1;
    force_l = 0;
    extra   = 0;
    repeat (8) begin
      @(negedge clk);
      if (cwr || start || busy) extra++;
    end
    check_eq("idle_after_reset", extra, 0);
    #1 ready = 1'b1;
    @(negedge clk);
    #1 ready = 1'b0;
    for (int c = 0; c < 300 && exp_idx < 3; c++) begin
      @(negedge clk);
      #1;
    end
    check_eq("restart_writes", exp_idx, 3);
    check_eq("iaddr_in_range_2", addr_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

- Sequencer that sits in front of the 3x3 convolution engine and walks a 64x64 image in raster order.
- For each output position it fetches the 3x3 neighbourhood (zero-padded at the borders) from image memory and packs it onto the engine's 180-bit `pixel` bus.
- It then pulses `start`, waits for `finish`, applies ReLU to `result_fixed`, and writes the value to layer-0 memory.
- `busy` is held from the `ready` request until the last (4096th) write.

## Interface

Parameters:
- `IMG_W`, 64: image width/height in pixels (square, power of two).
- `AW`, 12: address width, log2(IMG_W*IMG_W).
- `DW`, 20: pixel/result width, signed 4.16 fixed point.

Ports:
- `clk`  in  1  rising-edge clock, sole clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `ready`  in  1  image memory loaded; request to start a frame.
- `busy`  out  1  frame in progress.
- `iaddr`  out  AW  image memory read address.
- `idata`  in  DW  image memory read data; valid one cycle after `iaddr`.
- `pixel`  out  9*DW  window to the engine. `[179:160]`=(y-1,x-1) … `[19:0]`=(y+1,x+1), row-major.
- `start`  out  1  one-cycle pulse to the engine.
- `result_fixed`  in  DW  engine result.
- `finish`  in  1  engine done pulse.
- `cwr`  out  1  layer-0 write strobe.
- `caddr_wr`  out  AW  write address, y*IMG_W+x.
- `cdata_wr`  out  DW  write data.

## Operation

- **States:** IDLE, FETCH, LAST, START, WAIT, WRITE.
- **IDLE:** on `ready`=1, go to FETCH with (x,y)=(0,0) and `busy`<=1. `ready` is ignored in every other state.
- **FETCH:** each cycle, issue the address of the next window slot k (0..8, row-major). The data returned for slot k-1 is stored into that slot.
  - A slot whose (y+dy, x+dx) falls outside 0..IMG_W-1 issues no meaningful read; the slot is loaded with 0.
  - `iaddr` holds its last value during such slots.
  - After slot 8 is issued, go to LAST, which captures slot 8.
- **START:** drive `start`=1 for exactly one cycle, then go to WAIT.
- **WAIT:** `pixel` is held stable until `finish`=1. On that cycle, latch `max(result_fixed, 0)` (sign bit set → 0) and go to WRITE.
- **WRITE:** `cwr`=1 for one cycle with `caddr_wr`=y*IMG_W+x.
  - Then advance x. On x wrap, x=0 and y increments. Go to FETCH.
  - After (63,63), go to IDLE and set `busy`<=0 in the same cycle.
- **Address arithmetic:** `iaddr`={y+dy, x+dx}, truncated to 6+6 bits. Only in-range coordinates are issued.
- **Reset:** asynchronous, from any state (including mid-fetch or mid-WAIT). Returns to IDLE with x=y=0 and window cleared.
- **Output reset values:** `busy`=0, `start`=0, `cwr`=0, `iaddr`=0, `caddr_wr`=0, `cdata_wr`=0, `pixel`=0.
- **`finish` outside WAIT:** ignored.

## Timing

- **Full fetch:** 9 issue cycles + 1 LAST cycle = 10 cycles.
- **Per output:** FETCH(10) + START(1) + engine latency L + WRITE(1).
  - L is measured from `start` to `finish`. L=11 with the current engine.
- **Frame:** 4096 outputs. `busy` rises the cycle after `ready` is sampled in IDLE.
- `cwr` is high for one cycle per output. `cdata_wr` and `caddr_wr` are stable during that cycle.
- **`pixel` stability:** constant from the START cycle through the `finish` cycle.

## Configuration

- **`CONV_WINDOW_REUSE_EN`** defined, for x>0:
  - WRITE shifts the window left by one column: slots 1,2 → 0,1; 4,5 → 3,4; 7,8 → 6,7.
  - FETCH then issues only slots 2, 5, 8, so the fetch takes 3+1 = 4 cycles.
  - x=0 always takes the full 9-slot fetch.
- **Macro undefined:** every position takes the full 9-slot fetch.
- **Invariant:** the `pixel` values and write sequence are identical in both builds; only the cycle counts differ.

## Structure

- **Shared package `conv_pkg`:**
  - IMG_W, AW, DW.
  - State encoding.
  - Slot-index constants (dx,dy per slot).
  - ReLU helper function.
- **Sub-module `conv_window_buf`:** 9xDW register file with load-slot, zero-slot, and shift-left-column operations. Outputs the packed 180-bit `pixel`.
- **Top level:** FSM, x/y counters, address generation.

## Test plan

- **Interior window:** image memory word at address a = a (20-bit). At (x,y)=(5,5), `pixel` = {260,261,262,324,325,326,388,389,390}, slot 0 first.
- **Corner padding:** at (0,0), `pixel` = {0,0,0,0,0,1,0,64,65}. At (63,63), `pixel` = {4030,4031,0,4094,4095,0,0,0,0}. No out-of-range `iaddr` is ever issued.
- **ReLU and write:** engine stub returns `result_fixed`=20'hFF000 then 20'h01800.
  - Writes are `cdata_wr`=0 then 20'h01800.
  - `caddr_wr`=0 then 1.
  - Exactly 4096 `cwr` pulses, and `busy` falls after address 4095.
- **Handshake:** engine stub with L=11, then L=30.
  - `start` is a single-cycle pulse.
  - `pixel` is unchanged until `finish`.
  - `ready` pulsed mid-frame has no effect.
- **Reset mid-WAIT:** assert `reset`=0 during WAIT. All outputs are 0 and the state is IDLE. After release, a new `ready` restarts at (0,0).
- **Reuse build:** with `CONV_WINDOW_REUSE_EN`, the (1,0) fetch is 4 cycles. The `pixel`/write streams match the non-reuse build bit-exactly over the full frame.
